// File: rtl/player_ctrl.sv
// -----------------------------------------------------------------------------
// player_ctrl
//
// Per-player motion and animation sequencer for one fighter. Button edges are
// captured on every clock, but the walk/jump/punch state machine, position,
// vertical velocity and walk animation only advance on the single-cycle
// frame_tick, which fires once per video frame during vertical blank. The
// sprite therefore never moves part-way through a scan.
//
// Optional feature macro: PLAYER_CTRL_AIR_CONTROL_EN
//   defined   -> left/right steer x (with clamp and facing update) while airborne
//   undefined -> x and facing_left are frozen while airborne
//
// Ports:
//   clk           pixel-domain clock
//   rst           synchronous, active-high reset
//   hCount        VGA horizontal counter
//   vCount        VGA vertical counter
//   btn_left      held level, walk left
//   btn_right     held level, walk right
//   btn_jump      rising edge requests a jump
//   btn_punch     rising edge requests a punch
//   player_x      sprite left edge
//   player_y      sprite top edge
//   sprite_frame  0 idle, 1/2 walk A/B, 3 jump, 4 punch
//   facing_left   mirror request to the pixel datapath
//   attacking     high for the whole punch
//   frame_tick    one-cycle pulse on the cycle the state advances
// -----------------------------------------------------------------------------
module player_ctrl #(
   parameter int X_INIT       = 200,
   parameter int X_MIN        = 144,
   parameter int X_MAX        = 655,
   parameter int GROUND_Y     = 266,
   parameter int WALK_STEP    = 2,
   parameter int JUMP_V0      = 12,
   parameter int GRAVITY      = 1,
   parameter int PUNCH_FRAMES = 12,
   parameter int ANIM_DIV     = 8,
   parameter int TICK_LINE    = 515
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [9:0] hCount,
   input  logic [9:0] vCount,
   input  logic       btn_left,
   input  logic       btn_right,
   input  logic       btn_jump,
   input  logic       btn_punch,
   output logic [9:0] player_x,
   output logic [9:0] player_y,
   output logic [2:0] sprite_frame,
   output logic       facing_left,
   output logic       attacking,
   output logic       frame_tick
);

   localparam int TW = ($clog2(PUNCH_FRAMES) < 1) ? 1 : $clog2(PUNCH_FRAMES);
   localparam logic [TW-1:0]      PUNCH_LAST = TW'(PUNCH_FRAMES - 1);
   localparam logic [2:0]         ANIM_LAST  = 3'(ANIM_DIV - 1);
   localparam logic signed [6:0]  VY0        = 7'(JUMP_V0);
   localparam logic signed [6:0]  GRAV       = 7'(GRAVITY);
   localparam logic signed [11:0] GROUND_S   = 12'(GROUND_Y);

   typedef enum logic [1:0] {IDLE, WALK, JUMP, PUNCH} state_t;

   state_t            state, state_n;
   logic [9:0]        x_n, y_n;
   logic signed [6:0] vy, vy_n;
   logic [TW-1:0]     punch_timer, punch_timer_n;
   logic [2:0]        anim_div, anim_div_n;
   logic              anim_phase, anim_phase_n;
   logic              facing_n;
   logic              jump_q, punch_q;
   logic              jump_pend, punch_pend;
   logic              jump_rise, punch_rise;
   logic              tick_det;
   logic              left_only, right_only;
   logic [10:0]       x_wide;
   logic [9:0]        x_stepped;
   logic signed [11:0] y_sum;

   assign tick_det   = (hCount == 10'd0) && (vCount == 10'(TICK_LINE));
   assign jump_rise  = btn_jump & ~jump_q;
   assign punch_rise = btn_punch & ~punch_q;
   assign left_only  = btn_left & ~btn_right;
   assign right_only = btn_right & ~btn_left;

   // One horizontal step in the held direction, saturated to the visible
   // range. The left step checks the lower bound before subtracting so the
   // 11-bit difference can never wrap around into a huge value.
   always_comb begin
      x_wide    = {1'b0, player_x} + 11'(WALK_STEP);
      x_stepped = player_x;
      if (right_only) begin
         if (x_wide > 11'(X_MAX)) x_stepped = 10'(X_MAX);
         else                     x_stepped = x_wide[9:0];
      end else begin
         x_wide = {1'b0, player_x} - 11'(WALK_STEP);
         if ({1'b0, player_x} < 11'(X_MIN + WALK_STEP)) x_stepped = 10'(X_MIN);
         else                                           x_stepped = x_wide[9:0];
      end
   end

   // Candidate height for the next airborne frame, kept signed and wide so
   // both the ground test and the clamp at the top of the screen are exact.
   always_comb begin
      y_sum = $signed({2'b00, player_y}) + $signed({{5{vy[6]}}, vy});
   end

   // Next-state and datapath decisions. Nothing changes except on frame_tick.
   // On the ground a pending punch beats a pending jump, which beats walking.
   // The walk animation divider only runs while the result is WALK and is
   // reset to phase A as soon as the player leaves it.
   always_comb begin
      state_n       = state;
      x_n           = player_x;
      y_n           = player_y;
      vy_n          = vy;
      punch_timer_n = punch_timer;
      facing_n      = facing_left;
      anim_div_n    = anim_div;
      anim_phase_n  = anim_phase;
      if (frame_tick) begin
         case (state)
            IDLE, WALK: begin
               if (punch_pend) begin
                  state_n       = PUNCH;
                  punch_timer_n = PUNCH_LAST;
               end else if (jump_pend) begin
                  state_n = JUMP;
                  vy_n    = -VY0;
               end else if (left_only || right_only) begin
                  state_n  = WALK;
                  x_n      = x_stepped;
                  facing_n = left_only;
               end else begin
                  state_n = IDLE;
               end
            end
            JUMP: begin
               if (y_sum >= GROUND_S) begin
                  y_n     = 10'(GROUND_Y);
                  vy_n    = '0;
                  state_n = IDLE;
               end else begin
                  y_n  = y_sum[11] ? 10'd0 : y_sum[9:0];
                  vy_n = vy + GRAV;
               end
`ifdef PLAYER_CTRL_AIR_CONTROL_EN
               if (left_only || right_only) begin
                  x_n      = x_stepped;
                  facing_n = left_only;
               end
`else
`endif
            end
            PUNCH: begin
               if (punch_timer == '0) state_n = IDLE;
               else                   punch_timer_n = punch_timer - 1'b1;
            end
            default: state_n = IDLE;
         endcase
         if (state_n == WALK) begin
            if (anim_div == ANIM_LAST) begin
               anim_div_n   = 3'd0;
               anim_phase_n = ~anim_phase;
            end else begin
               anim_div_n = anim_div + 3'd1;
            end
         end else begin
            anim_div_n   = 3'd0;
            anim_phase_n = 1'b0;
         end
      end
   end

   // State register plus edge capture. Pending requests are cleared on every
   // tick whether used or not; an edge landing on the tick cycle itself is
   // kept for the following frame instead of acting now or being lost.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         player_x    <= 10'(X_INIT);
         player_y    <= 10'(GROUND_Y);
         vy          <= '0;
         punch_timer <= '0;
         facing_left <= 1'b0;
         anim_div    <= 3'd0;
         anim_phase  <= 1'b0;
         frame_tick  <= 1'b0;
         jump_q      <= 1'b0;
         punch_q     <= 1'b0;
         jump_pend   <= 1'b0;
         punch_pend  <= 1'b0;
      end else begin
         state       <= state_n;
         player_x    <= x_n;
         player_y    <= y_n;
         vy          <= vy_n;
         punch_timer <= punch_timer_n;
         facing_left <= facing_n;
         anim_div    <= anim_div_n;
         anim_phase  <= anim_phase_n;
         frame_tick  <= tick_det;
         jump_q      <= btn_jump;
         punch_q     <= btn_punch;
         jump_pend   <= frame_tick ? jump_rise  : (jump_pend  | jump_rise);
         punch_pend  <= frame_tick ? punch_rise : (punch_pend | punch_rise);
      end
   end

   // Sprite selection and the attack flag come straight from registered
   // state, so there is no path from the buttons to these outputs.
   always_comb begin
      sprite_frame = 3'd0;
      attacking    = 1'b0;
      case (state)
         WALK:    sprite_frame = anim_phase ? 3'd2 : 3'd1;
         JUMP:    sprite_frame = 3'd3;
         PUNCH: begin
            sprite_frame = 3'd4;
            attacking    = 1'b1;
         end
         default: sprite_frame = 3'd0;
      endcase
   end

endmodule

// File: tb/tb_player_ctrl.sv
// -----------------------------------------------------------------------------
// tb_player_ctrl
//
// Directed bench for player_ctrl. The VGA counters are driven directly so a
// "frame" is only a handful of clocks: each step sets the buttons, places the
// counters on the tick position for one cycle and then compares the outputs
// two clocks later. A small behavioural model of the fighter produces the
// expected outputs, which go through a scoreboard queue; fixed literal values
// from the intended behaviour are checked at key points as well.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_player_ctrl;

   localparam int TICK_LINE = 515;

   logic       clk = 1'b0;
   logic       rst;
   logic [9:0] hCount, vCount;
   logic       btn_left, btn_right, btn_jump, btn_punch;
   logic [9:0] player_x, player_y;
   logic [2:0] sprite_frame;
   logic       facing_left, attacking, frame_tick;

   int compared   = 0;
   int mismatched = 0;

   player_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .hCount       (hCount),
      .vCount       (vCount),
      .btn_left     (btn_left),
      .btn_right    (btn_right),
      .btn_jump     (btn_jump),
      .btn_punch    (btn_punch),
      .player_x     (player_x),
      .player_y     (player_y),
      .sprite_frame (sprite_frame),
      .facing_left  (facing_left),
      .attacking    (attacking),
      .frame_tick   (frame_tick)
   );

   always #5 clk = ~clk;

   typedef enum int {M_IDLE, M_WALK, M_JUMP, M_PUNCH} mstate_t;

   typedef struct {
      logic [9:0] x;
      logic [9:0] y;
      logic [2:0] frame;
      logic       facing;
      logic       attacking;
   } exp_t;

   exp_t    sb[$];
   mstate_t m_state;
   int      m_x, m_y, m_vy, m_timer, m_div;
   bit      m_phase, m_facing, m_jpend, m_ppend;

   function automatic int clampX(input int v);
      if (v < 144) return 144;
      if (v > 655) return 655;
      return v;
   endfunction

   task automatic modelReset();
      m_state  = M_IDLE;
      m_x      = 200;
      m_y      = 266;
      m_vy     = 0;
      m_timer  = 0;
      m_div    = 0;
      m_phase  = 0;
      m_facing = 0;
      m_jpend  = 0;
      m_ppend  = 0;
   endtask

   // Fighter behaviour for one frame tick, written from the intended rules.
   task automatic modelTick(input logic l, input logic r);
      bit lo, ro;
      int ny;
      lo = l && !r;
      ro = r && !l;
      case (m_state)
         M_IDLE, M_WALK: begin
            if (m_ppend) begin
               m_state = M_PUNCH;
               m_timer = 11;
            end else if (m_jpend) begin
               m_state = M_JUMP;
               m_vy    = -12;
            end else if (lo || ro) begin
               m_state  = M_WALK;
               m_x      = clampX(m_x + (ro ? 2 : -2));
               m_facing = lo;
            end else begin
               m_state = M_IDLE;
            end
         end
         M_JUMP: begin
            ny = m_y + m_vy;
            if (ny >= 266) begin
               m_y     = 266;
               m_vy    = 0;
               m_state = M_IDLE;
            end else begin
               m_y  = (ny < 0) ? 0 : ny;
               m_vy = m_vy + 1;
            end
`ifdef PLAYER_CTRL_AIR_CONTROL_EN
            if (lo || ro) begin
               m_x      = clampX(m_x + (ro ? 2 : -2));
               m_facing = lo;
            end
`endif
         end
         default: begin
            if (m_timer == 0) m_state = M_IDLE;
            else              m_timer = m_timer - 1;
         end
      endcase
      if (m_state == M_WALK) begin
         m_div = m_div + 1;
         if (m_div == 8) begin
            m_div   = 0;
            m_phase = !m_phase;
         end
      end else begin
         m_div   = 0;
         m_phase = 0;
      end
      m_jpend = 0;
      m_ppend = 0;
   endtask

   task automatic pushExpected();
      exp_t e;
      e.x         = 10'(m_x);
      e.y         = 10'(m_y);
      e.frame     = (m_state == M_WALK)  ? (m_phase ? 3'd2 : 3'd1) :
                    (m_state == M_JUMP)  ? 3'd3 :
                    (m_state == M_PUNCH) ? 3'd4 : 3'd0;
      e.facing    = m_facing;
      e.attacking = (m_state == M_PUNCH);
      sb.push_back(e);
   endtask

   task automatic checkValue(input string tag, input logic [9:0] got, input logic [9:0] want);
      compared++;
      assert (got === want) else begin
         mismatched++;
         $error("[TB] FAIL %s: got %0d expected %0d", tag, got, want);
      end
   endtask

   // Pops the oldest expectation and compares every output against it.
   task automatic checkOutput(input string tag);
      exp_t e;
      compared++;
      assert (sb.size() > 0) else begin
         mismatched++;
         $error("[TB] FAIL %s: scoreboard empty, got %0d entries expected 1", tag, sb.size());
      end
      if (sb.size() > 0) begin
         e = sb.pop_front();
         compared++;
         assert (player_x === e.x) else begin
            mismatched++;
            $error("[TB] FAIL %s player_x: got %0d expected %0d", tag, player_x, e.x);
         end
         compared++;
         assert (player_y === e.y) else begin
            mismatched++;
            $error("[TB] FAIL %s player_y: got %0d expected %0d", tag, player_y, e.y);
         end
         compared++;
         assert (sprite_frame === e.frame) else begin
            mismatched++;
            $error("[TB] FAIL %s sprite_frame: got %0d expected %0d", tag, sprite_frame, e.frame);
         end
         compared++;
         assert (facing_left === e.facing) else begin
            mismatched++;
            $error("[TB] FAIL %s facing_left: got %0b expected %0b", tag, facing_left, e.facing);
         end
         compared++;
         assert (attacking === e.attacking) else begin
            mismatched++;
            $error("[TB] FAIL %s attacking: got %0b expected %0b", tag, attacking, e.attacking);
         end
      end
   endtask

   // One compressed frame: buttons settle, optional jump/punch pulses, then
   // the counters sit on the tick position for exactly one clock. lateJump
   // raises btn_jump during the frame_tick cycle itself.
   task automatic applyStimulus(input string tag, input logic l, input logic r,
                                input logic j, input logic p, input logic lateJump);
      btn_left  = l;
      btn_right = r;
      btn_jump  = j;
      btn_punch = p;
      @(negedge clk);
      @(negedge clk);
      btn_jump  = 1'b0;
      btn_punch = 1'b0;
      @(negedge clk);
      if (j) m_jpend = 1;
      if (p) m_ppend = 1;
      hCount = 10'd0;
      vCount = 10'(TICK_LINE);
      @(negedge clk);
      hCount = 10'd100;
      vCount = 10'd0;
      checkValue({tag, "_tick_hi"}, {9'd0, frame_tick}, 10'd1);
      if (lateJump) btn_jump = 1'b1;
      modelTick(l, r);
      if (lateJump) m_jpend = 1;
      pushExpected();
      @(negedge clk);
      checkValue({tag, "_tick_lo"}, {9'd0, frame_tick}, 10'd0);
      checkOutput(tag);
   endtask

   task automatic applyReset(input string tag);
      rst = 1'b1;
      @(negedge clk);
      modelReset();
      pushExpected();
      checkOutput(tag);
      checkValue({tag, "_tick"}, {9'd0, frame_tick}, 10'd0);
      rst = 1'b0;
   endtask

   initial begin
      rst       = 1'b1;
      hCount    = 10'd100;
      vCount    = 10'd0;
      btn_left  = 1'b0;
      btn_right = 1'b0;
      btn_jump  = 1'b0;
      btn_punch = 1'b0;
      repeat (3) @(negedge clk);
      $display("[TB] reset state");
      applyReset("reset");

      $display("[TB] near-miss counter positions must not tick");
      hCount = 10'd0;
      vCount = 10'(TICK_LINE - 1);
      @(negedge clk);
      hCount = 10'd1;
      vCount = 10'(TICK_LINE);
      checkValue("nomatch_v", {9'd0, frame_tick}, 10'd0);
      @(negedge clk);
      hCount = 10'd100;
      vCount = 10'd0;
      checkValue("nomatch_h", {9'd0, frame_tick}, 10'd0);

      $display("[TB] idle frames");
      for (int i = 0; i < 3; i++) applyStimulus("idle", 0, 0, 0, 0, 0);
      checkValue("idle_x", player_x, 10'd200);
      checkValue("idle_y", player_y, 10'd266);

      $display("[TB] walk right");
      for (int i = 0; i < 10; i++) begin
         applyStimulus("walk_right", 0, 1, 0, 0, 0);
         if (i == 6) checkValue("anim_a", {7'd0, sprite_frame}, 10'd1);
         if (i == 7) checkValue("anim_b", {7'd0, sprite_frame}, 10'd2);
      end
      checkValue("right_x", player_x, 10'd220);
      checkValue("right_face", {9'd0, facing_left}, 10'd0);

      $display("[TB] walk left into X_MIN");
      for (int i = 0; i < 37; i++) applyStimulus("walk_left", 1, 0, 0, 0, 0);
      checkValue("left_x146", player_x, 10'd146);
      for (int i = 0; i < 5; i++) applyStimulus("clamp_left", 1, 0, 0, 0, 0);
      checkValue("left_xmin", player_x, 10'd144);
      checkValue("left_face", {9'd0, facing_left}, 10'd1);

      $display("[TB] jump arc");
      applyStimulus("jump_start", 0, 0, 1, 0, 0);
      checkValue("jump_frame", {7'd0, sprite_frame}, 10'd3);
      for (int k = 0; k < 25; k++) begin
         applyStimulus("jump_air", 0, 0, 0, 0, 0);
         if (k == 0)  checkValue("jump_y1", player_y, 10'd254);
         if (k == 1)  checkValue("jump_y2", player_y, 10'd243);
         if (k == 2)  checkValue("jump_y3", player_y, 10'd233);
         if (k == 23) checkValue("jump_last_air", {7'd0, sprite_frame}, 10'd3);
      end
      checkValue("land_y", player_y, 10'd266);
      checkValue("land_frame", {7'd0, sprite_frame}, 10'd0);

      $display("[TB] punch while walking");
      applyStimulus("pre_punch_walk", 0, 1, 0, 0, 0);
      applyStimulus("pre_punch_walk", 0, 1, 0, 0, 0);
      applyStimulus("punch_start", 0, 1, 0, 1, 0);
      for (int k = 1; k <= 12; k++) begin
         applyStimulus("punch_hold", 0, 1, 0, (k == 5), 0);
         if (k == 11) checkValue("punch_last", {9'd0, attacking}, 10'd1);
      end
      checkValue("punch_done", {9'd0, attacking}, 10'd0);
      checkValue("punch_x", player_x, 10'd148);

      $display("[TB] jump and punch in the same frame");
      applyStimulus("jp_same", 0, 0, 1, 1, 0);
      checkValue("jp_punch_wins", {7'd0, sprite_frame}, 10'd4);
      for (int k = 0; k < 13; k++) applyStimulus("jp_after", 0, 0, 0, 0, 0);
      checkValue("jp_no_jump", player_y, 10'd266);

      $display("[TB] left and right together");
      for (int i = 0; i < 2; i++) applyStimulus("both_dirs", 1, 1, 0, 0, 0);
      checkValue("both_x", player_x, 10'd148);
      checkValue("both_frame", {7'd0, sprite_frame}, 10'd0);

      $display("[TB] jump edge on the tick cycle");
      applyStimulus("late_jump", 0, 0, 0, 0, 1);
      checkValue("late_not_now", {7'd0, sprite_frame}, 10'd0);
      applyStimulus("late_jump_next", 0, 0, 0, 0, 0);
      checkValue("late_taken", {7'd0, sprite_frame}, 10'd3);

      $display("[TB] right held while airborne, then reset mid-jump");
      for (int i = 0; i < 3; i++) applyStimulus("air_right", 0, 1, 0, 0, 0);
`ifdef PLAYER_CTRL_AIR_CONTROL_EN
      checkValue("air_x", player_x, 10'd154);
`else
      checkValue("air_x", player_x, 10'd148);
`endif
      applyReset("reset_jump");
      checkValue("rj_x", player_x, 10'd200);
      checkValue("rj_y", player_y, 10'd266);

      $display("[TB] reset mid-punch");
      applyStimulus("punch_again", 0, 0, 0, 1, 0);
      applyReset("reset_punch");

      $display("[TB] walk right into X_MAX");
      for (int i = 0; i < 230; i++) applyStimulus("clamp_right", 0, 1, 0, 0, 0);
      checkValue("right_xmax", player_x, 10'd655);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
